// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with write bypass, hardwired zero register and busy scoreboard
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic [DATA_W-1:0] rd1_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              flush,
    output logic              rd0_busy,
    output logic              rd1_busy,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W:0]   cnt_next;

    logic wr_zero;
    logic issue_zero;
    logic wr_live;
    logic set_eff;
    logic clr_eff;
    logic cnt_inc;
    logic cnt_dec;

    assign wr_zero    = (ZERO_REG != 0) && (wr_addr == '0);
    assign issue_zero = (ZERO_REG != 0) && (issue_addr == '0);
    assign wr_live    = wr_en && !rst && !wr_zero;
    assign set_eff    = issue_en && !flush && !issue_zero;
    assign clr_eff    = wr_en && !flush && !wr_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_live) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A same-index set and clear cancel in the count because the newer producer keeps the bit.
    always_comb begin
        cnt_inc = set_eff && !busy[issue_addr];
        cnt_dec = clr_eff && busy[wr_addr] && !(set_eff && (issue_addr == wr_addr));
        busy_next = busy;
        if (clr_eff) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (set_eff) begin
            busy_next[issue_addr] = 1'b1;
        end
        cnt_next = busy_cnt;
        if (cnt_inc && !cnt_dec) begin
            cnt_next = busy_cnt + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            cnt_next = busy_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];

    assign rd_addr[0] = rd0_addr;
    assign rd_addr[1] = rd1_addr;
    assign rd0_data   = rd_data[0];
    assign rd1_data   = rd_data[1];
    assign rd0_busy   = rd_busy[0];
    assign rd1_busy   = rd_busy[1];

    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            rd_data[p] = mem[rd_addr[p]];
            rd_busy[p] = busy[rd_addr[p]];
            if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end else if ((BYPASS != 0) && wr_en && !rst && (wr_addr == rd_addr[p])) begin
                rd_data[p] = wr_data;
                rd_busy[p] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - randomized check of reg_file_sb against an array model, bypass and no-bypass builds
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst, wr_en, issue_en, flush;
    logic [4:0]  wr_addr, rd0_addr, rd1_addr, issue_addr;
    logic [31:0] wr_data;

    logic [31:0] b_rd0_data, b_rd1_data, n_rd0_data, n_rd1_data;
    logic        b_rd0_busy, b_rd1_busy, n_rd0_busy, n_rd1_busy;
    logic [5:0]  b_busy_cnt, n_busy_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_mem [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .rd0_data(b_rd0_data), .rd1_data(b_rd1_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
        .rd0_busy(b_rd0_busy), .rd1_busy(b_rd1_busy), .busy_cnt(b_busy_cnt)
    );

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .rd0_data(n_rd0_data), .rd1_data(n_rd1_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
        .rd0_busy(n_rd0_busy), .rd1_busy(n_rd1_busy), .busy_cnt(n_busy_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit bp);
        if (a == 0) return 32'h0;
        if (bp && wr_en && !rst && wr_addr == a) return wr_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit bp);
        if (a == 0) return 1'b0;
        if (bp && wr_en && !rst && wr_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic ie, input logic [4:0] ia, input logic fl);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        rd0_addr = a0; rd1_addr = a1; issue_en = ie; issue_addr = ia; flush = fl;
        #1;
    endtask

    task automatic check_outputs();
        check("b_rd0_data", b_rd0_data, exp_data(rd0_addr, 1'b1));
        check("b_rd1_data", b_rd1_data, exp_data(rd1_addr, 1'b1));
        check("b_rd0_busy", 32'(b_rd0_busy), 32'(exp_busy(rd0_addr, 1'b1)));
        check("b_rd1_busy", 32'(b_rd1_busy), 32'(exp_busy(rd1_addr, 1'b1)));
        check("b_busy_cnt", 32'(b_busy_cnt), 32'(model_cnt()));
        check("n_rd0_data", n_rd0_data, exp_data(rd0_addr, 1'b0));
        check("n_rd1_data", n_rd1_data, exp_data(rd1_addr, 1'b0));
        check("n_rd0_busy", 32'(n_rd0_busy), 32'(exp_busy(rd0_addr, 1'b0)));
        check("n_rd1_busy", 32'(n_rd1_busy), 32'(exp_busy(rd1_addr, 1'b0)));
        check("n_busy_cnt", 32'(n_busy_cnt), 32'(model_cnt()));
    endtask

    // Model state advances from the rules, using the input values held across the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i] = 32'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else begin
                if (wr_en) m_busy[wr_addr] = 1'b0;
                if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    logic [4:0] ra, rb;

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 32'hx;
            m_busy[i] = 1'bx;
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 0, 0, 5'(a), 5'(31 - a), 0, 0, 0);
            check_outputs();
            check("rst_rd0_zero", b_rd0_data, 32'h0);
            check("rst_busy_cnt", 32'(b_busy_cnt), 32'h0);
            tick();
        end

        drive(0, 1, 5, 32'hDEADBEEF, 1, 2, 0, 0, 0); check_outputs(); tick();
        drive(0, 0, 0, 0, 5, 5, 0, 0, 0); check_outputs();
        check("r5_read", n_rd0_data, 32'hDEADBEEF); tick();
        drive(0, 1, 0, 32'h12345678, 0, 0, 0, 0, 0); check_outputs(); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); check_outputs();
        check("r0_read", b_rd0_data, 32'h0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); check_outputs();
        check("r0_issue_cnt", 32'(b_busy_cnt), 32'h0); tick();

        drive(0, 1, 7, 32'hA5A5A5A5, 7, 7, 0, 0, 0); check_outputs();
        check("byp_rd0", b_rd0_data, 32'hA5A5A5A5);
        check("byp_rd1", b_rd1_data, 32'hA5A5A5A5);
        check("nobyp_old", n_rd0_data, 32'h0); tick();
        drive(0, 0, 0, 0, 7, 7, 0, 0, 0); check_outputs();
        check("nobyp_new", n_rd1_data, 32'hA5A5A5A5); tick();

        drive(0, 0, 0, 0, 3, 3, 1, 3, 0); check_outputs(); tick();
        drive(0, 0, 0, 0, 3, 4, 1, 4, 0); check_outputs();
        check("r3_busy", 32'(b_rd0_busy), 32'h1);
        check("cnt_one", 32'(b_busy_cnt), 32'h1); tick();
        drive(0, 1, 3, 32'h33, 3, 4, 0, 0, 0); check_outputs();
        check("cnt_two", 32'(b_busy_cnt), 32'h2);
        check("wb_byp_busy", 32'(b_rd0_busy), 32'h0);
        check("wb_nobyp_busy", 32'(n_rd0_busy), 32'h1); tick();
        drive(0, 0, 0, 0, 3, 4, 1, 9, 0); check_outputs();
        check("cnt_after_wb", 32'(b_busy_cnt), 32'h1); tick();

        drive(0, 1, 9, 32'h99, 9, 4, 1, 9, 0); check_outputs();
        check("cnt_pre_same", 32'(b_busy_cnt), 32'h2); tick();
        drive(0, 0, 0, 0, 9, 9, 0, 0, 0); check_outputs();
        check("same_busy", 32'(n_rd0_busy), 32'h1);
        check("same_cnt", 32'(b_busy_cnt), 32'h2); tick();

        drive(0, 1, 11, 32'h55, 11, 10, 1, 10, 1); check_outputs(); tick();
        drive(0, 0, 0, 0, 11, 10, 0, 0, 0); check_outputs();
        check("flush_cnt", 32'(n_busy_cnt), 32'h0);
        check("flush_r11", n_rd0_data, 32'h55);
        check("flush_r10", 32'(b_rd1_busy), 32'h0); tick();

        drive(0, 1, 2, 32'h11, 2, 6, 1, 2, 0); check_outputs(); tick();
        drive(1, 1, 2, 32'h99, 2, 6, 1, 6, 0);
        check("rst_hold_r2", b_rd0_data, 32'h11);
        tick();
        drive(0, 0, 0, 0, 2, 6, 0, 0, 0); check_outputs();
        check("rstmid_r2", b_rd0_data, 32'h0);
        check("rstmid_r6", 32'(b_rd1_busy), 32'h0);
        check("rstmid_cnt", 32'(b_busy_cnt), 32'h0); tick();

        for (int c = 0; c < 1500; c++) begin
            logic [4:0] wa, ia;
            wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            ia = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            ra = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 9));
            rb = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom);
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 1) != 0), wa, $urandom, ra, rb,
                  ($urandom_range(0, 2) != 0), ia, ($urandom_range(0, 29) == 0));
            if (!rst) check_outputs();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised general-purpose register file with write-to-read bypass, a hardwired-zero register option and a per-register busy scoreboard. It sits in the CPU decode stage. It supplies two read operands per cycle and reports whether each operand's producer is still in flight, so decode can stall on RAW hazards. The write port is driven by writeback. Entries are marked busy at issue and cleared at writeback.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to reads

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  writeback write strobe
- wr_addr  in  ADDR_W  write register index
- wr_data  in  DATA_W  write data
- rd0_addr  in  ADDR_W  read port 0 index
- rd1_addr  in  ADDR_W  read port 1 index
- rd0_data  out  DATA_W  read port 0 data (combinational)
- rd1_data  out  DATA_W  read port 1 data (combinational)
- issue_en  in  1  instruction with a destination register issued this cycle
- issue_addr  in  ADDR_W  destination index being issued
- flush  in  1  pipeline flush; clears all busy bits
- rd0_busy  out  1  port 0 operand not yet available
- rd1_busy  out  1  port 1 operand not yet available
- busy_cnt  out  ADDR_W+1  number of registers currently busy

## Operation
- Storage: 2**ADDR_W x DATA_W array mem, plus a 2**ADDR_W-bit busy vector.
- Write: if wr_en and not rst, mem[wr_addr] <= wr_data at the edge. When ZERO_REG=1 and wr_addr==0, the write is dropped.
- Read port n (identical for 0 and 1):
  - ZERO_REG=1 and rdn_addr==0: data 0, busy 0.
  - Otherwise, if BYPASS=1, wr_en=1, rst=0 and wr_addr==rdn_addr: data = wr_data and busy = 0.
  - Otherwise data = mem[rdn_addr] and busy = busy[rdn_addr].
- Busy update per edge, in priority order:
  - rst: clear all.
  - flush: clear all; issue_en is ignored that cycle; the mem write still occurs.
  - Otherwise:
    - wr_en clears busy[wr_addr].
    - issue_en sets busy[issue_addr].
    - If both target the same index, the set wins, because the newer producer owns the register.
- Register 0 never becomes busy when ZERO_REG=1.
- busy_cnt is a registered population count, kept consistent with the busy vector every cycle:
  - +1 for an effective set of a clear bit.
  - −1 for an effective clear of a set bit.
  - Net 0 when set and clear cancel.
  - 0 after flush or rst.
- Re-issuing an already-busy register leaves busy_cnt unchanged. Writing a non-busy register leaves busy_cnt unchanged.

## Timing
- Reset values:
  - all mem entries 0, all busy bits 0, busy_cnt 0.
  - Hence rd0_data, rd1_data, rd0_busy and rd1_busy are 0 in the first cycle after reset for any address.
- While rst is high:
  - writes, issues and bypass are suppressed.
  - Read outputs show mem contents as they were before the reset edge.
- Read latency: 0 cycles (combinational from addresses and mem).
- Write-to-read latency: 0 cycles with BYPASS=1 (same cycle); 1 cycle with BYPASS=0.
- Issue-to-busy latency: 1 cycle; busy is visible on reads from the cycle after issue_en.
- Writeback clear: with BYPASS=1 the busy output drops in the same cycle as wr_en; with BYPASS=0 it drops the next cycle.
- Reset mid-operation: a wr_en or issue_en coinciding with rst has no effect.
- Both read ports may address the same register; both return identical data and busy.

## Test plan
- Reset then read: assert rst for 1 cycle, then read all 32 addresses on both ports -> every rdn_data = 0, rdn_busy = 0, busy_cnt = 0.
- Write/read and zero register:
  - write 0xDEADBEEF to r5, read r5 next cycle -> 0xDEADBEEF.
  - write 0x12345678 to r0, read r0 -> 0.
  - issue r0 -> busy_cnt stays 0.
- Bypass (BYPASS=1): wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5 with rd0_addr=rd1_addr=7 in the same cycle -> both ports read 0xA5A5A5A5 that cycle. Repeat with BYPASS=0 -> old value that cycle, new value the next.
- Scoreboard:
  - issue r3 -> next cycle rd0_busy=1 on r3 and busy_cnt=1.
  - issue r4 -> busy_cnt=2.
  - writeback r3 -> rd0_busy=0 the same cycle and busy_cnt=1 after the edge.
- Simultaneous events:
  - same cycle, wr_en r9 and issue_en r9 (r9 busy) -> r9 stays busy and busy_cnt is unchanged.
  - flush together with issue r10 and wr_en r11=0x55 -> all busy cleared, busy_cnt=0, r11 reads 0x55, r10 not busy.
- Reset mid-stream: with r2 busy and r2=0x11, assert rst while wr_en writes r2=0x99 and issue_en targets r6 -> after reset r2 reads 0, r6 is not busy, busy_cnt=0.
